// File: rtl/dac_seq_pkg.sv
// Shared constants and width helpers for the DAC frame sequencer.
// Contents: default per-channel code width and channel count, frame-width
// and FIFO level-width helper functions used to size ports consistently.
package dac_seq_pkg;

   localparam int DAC_WIDTH    = 10;
   localparam int DAC_CHANNELS = 2;

   // Total bits in one packed frame (channel k at [k*width +: width]).
   function automatic int frame_w(input int width, input int channels);
      return width * channels;
   endfunction

   // Bits needed to count 0..depth frames inclusive.
   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dac_frame_fifo.sv
// Single-clock frame FIFO with occupancy count; no fall-through (a push is
// never visible to a pop on the same edge).
// Ports: clk/reset (sync, active-high), push/push_data, pop/pop_data
// (head-of-queue, combinational), full, empty, level (0..DEPTH).
module dac_frame_fifo
   import dac_seq_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [DATA_W-1:0]         push_data,
   input  logic                      pop,
   output logic [DATA_W-1:0]         pop_data,
   output logic                      full,
   output logic                      empty,
   output logic [level_w(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              push_ok, pop_ok;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A push into a full FIFO is refused even if a pop frees a slot on the
   // same edge; the caller sees s_ready low for that cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; contents are irrelevant while level is 0.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Buffers multi-channel DAC frames and releases one per sample-rate tick.
// Ports: clk/reset (sync, active-high), enable + rate_div (tick period-1),
// s_valid/s_ready/s_data frame input, dac_code/dac_update outputs, sticky
// underrun with underrun_clr, level = frames stored.
module dac_frame_sequencer
   import dac_seq_pkg::*;
#(
   parameter int WIDTH    = DAC_WIDTH,
   parameter int CHANNELS = DAC_CHANNELS,
   parameter int DEPTH    = 8,
   parameter int DIV_W    = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [DIV_W-1:0]                     rate_div,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [frame_w(WIDTH, CHANNELS)-1:0]  s_data,
   output logic [frame_w(WIDTH, CHANNELS)-1:0]  dac_code,
   output logic                                 dac_update,
   output logic                                 underrun,
   input  logic                                 underrun_clr,
   output logic [level_w(DEPTH)-1:0]            level
);

   localparam int FW = frame_w(WIDTH, CHANNELS);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [FW-1:0]    dac_code_q, dac_code_d;
   logic             dac_update_q, dac_update_d;
   logic             underrun_q, underrun_d;
   logic [FW-1:0]    fifo_dout;
   logic             fifo_full, fifo_empty;
   logic             tick, pop;

   dac_frame_fifo #(
      .DATA_W (FW),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (s_valid && s_ready),
      .push_data (s_data),
      .pop       (pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   // Depends only on registered FIFO occupancy, never on s_valid.
   assign s_ready = !fifo_full;

   // Exact-match compare: if rate_div drops below the running count, the
   // counter runs on through all-ones and wraps rather than ticking early.
   assign tick = enable && (cnt_q == rate_div);
   // fifo_empty reflects state before this edge, so a same-edge push cannot
   // satisfy this tick.
   assign pop  = tick && !fifo_empty;

   always_comb begin
      cnt_d        = cnt_q;
      dac_code_d   = dac_code_q;
      dac_update_d = pop;
      underrun_d   = underrun_q;

      if (!enable)   cnt_d = '0;
      else if (tick) cnt_d = '0;
      else           cnt_d = cnt_q + DIV_W'(1);

      if (pop) dac_code_d = fifo_dout;

      // A fresh underrun wins over a simultaneous clear.
      if (tick && fifo_empty) underrun_d = 1'b1;
      else if (underrun_clr)  underrun_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         dac_code_q   <= '0;
         dac_update_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dac_code_q   <= dac_code_d;
         dac_update_q <= dac_update_d;
         underrun_q   <= underrun_d;
      end
   end

   assign dac_code   = dac_code_q;
   assign dac_update = dac_update_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Self-checking bench for dac_frame_sequencer: fixed vector table, corner
// sequences (full FIFO, reset mid-stream) and randomized traffic, all
// compared against a queue-based reference model.
module tb_dac_frame_sequencer;
   import dac_seq_pkg::*;

   localparam int WIDTH    = 10;
   localparam int CHANNELS = 2;
   localparam int DEPTH    = 8;
   localparam int DIV_W    = 16;
   localparam int FW       = WIDTH * CHANNELS;
   localparam int LW       = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [DIV_W-1:0] rate_div;
   logic             s_valid;
   logic             s_ready;
   logic [FW-1:0]    s_data;
   logic [FW-1:0]    dac_code;
   logic             dac_update;
   logic             underrun;
   logic             underrun_clr;
   logic [LW-1:0]    level;

   always #5 clk = ~clk;

   dac_frame_sequencer #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .DEPTH    (DEPTH),
      .DIV_W    (DIV_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .rate_div     (rate_div),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .dac_code     (dac_code),
      .dac_update   (dac_update),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .level        (level)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [FW-1:0] m_fifo[$];
   int            m_cnt  = 0;
   logic [FW-1:0] m_code = '0;
   bit            m_upd  = 0;
   bit            m_und  = 0;

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit tick, was_empty, was_full;
      if (reset) begin
         m_fifo.delete();
         m_cnt  = 0;
         m_code = '0;
         m_upd  = 0;
         m_und  = 0;
      end else begin
         tick      = enable && (m_cnt == int'(rate_div));
         was_empty = (m_fifo.size() == 0);
         was_full  = (m_fifo.size() == DEPTH);
         m_upd     = tick && !was_empty;
         if (m_upd) m_code = m_fifo.pop_front();
         if (tick && was_empty) m_und = 1;
         else if (underrun_clr) m_und = 0;
         if (s_valid && !was_full) m_fifo.push_back(s_data);
         if (!enable || tick) m_cnt = 0;
         else m_cnt = (m_cnt + 1) % (1 << DIV_W);
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check("model dac_code",   dac_code,   m_code);
      check("model dac_update", dac_update, m_upd);
      check("model underrun",   underrun,   m_und);
      check("model level",      level,      m_fifo.size());
      check("model s_ready",    s_ready,    m_fifo.size() != DEPTH);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit            rst, en;
      int            div;
      bit            sv;
      logic [FW-1:0] sd;
      bit            clr;
      logic [FW-1:0] code;
      bit            upd, und;
      int            lvl;
      bit            rdy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit en, int div, bit sv, logic [FW-1:0] sd, bit clr,
                               logic [FW-1:0] code, bit upd, bit und, int lvl, bit rdy);
      vec_t v;
      v.rst = rst; v.en = en; v.div = div; v.sv = sv; v.sd = sd; v.clr = clr;
      v.code = code; v.upd = upd; v.und = und; v.lvl = lvl; v.rdy = rdy;
      return v;
   endfunction

   logic [FW-1:0] frames [9];
   int            cnt;
   bit            acc;

   initial begin
      reset = 1'b1; enable = 1'b0; rate_div = '0;
      s_valid = 1'b0; s_data = '0; underrun_clr = 1'b0;

      // Reset/idle, preload, rate 4 pops, underrun, clear vs set, push on empty tick.
      tbl.push_back(mk(1,0,0,0,20'h00000,0, 20'h00000,0,0,0,1));
      tbl.push_back(mk(1,0,0,0,20'h00000,0, 20'h00000,0,0,0,1));
      tbl.push_back(mk(0,0,0,1,20'h003FF,0, 20'h00000,0,0,1,1));
      tbl.push_back(mk(0,0,0,1,20'hAA955,0, 20'h00000,0,0,2,1));
      tbl.push_back(mk(0,0,0,1,20'h12345,0, 20'h00000,0,0,3,1));
      tbl.push_back(mk(0,1,3,0,20'h00000,0, 20'h00000,0,0,3,1));
      tbl.push_back(mk(0,1,3,0,20'h00000,0, 20'h00000,0,0,3,1));
      tbl.push_back(mk(0,1,3,0,20'h00000,0, 20'h00000,0,0,3,1));
      tbl.push_back(mk(0,1,3,0,20'h00000,0, 20'h003FF,1,0,2,1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,3,0,20'h0,0, 20'h003FF,0,0,2,1));
      tbl.push_back(mk(0,1,3,0,20'h00000,0, 20'hAA955,1,0,1,1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,3,0,20'h0,0, 20'hAA955,0,0,1,1));
      tbl.push_back(mk(0,1,3,0,20'h00000,0, 20'h12345,1,0,0,1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,3,0,20'h0,0, 20'h12345,0,0,0,1));
      tbl.push_back(mk(0,1,3,0,20'h00000,0, 20'h12345,0,1,0,1));
      tbl.push_back(mk(0,0,3,0,20'h00000,1, 20'h12345,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,20'h00000,1, 20'h12345,0,1,0,1));
      tbl.push_back(mk(0,1,0,1,20'h54321,0, 20'h12345,0,1,1,1));
      tbl.push_back(mk(0,1,0,0,20'h00000,0, 20'h54321,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,20'h00000,1, 20'h54321,0,0,0,1));

      foreach (tbl[i]) begin
         reset = tbl[i].rst; enable = tbl[i].en; rate_div = DIV_W'(tbl[i].div);
         s_valid = tbl[i].sv; s_data = tbl[i].sd; underrun_clr = tbl[i].clr;
         cyc();
         check($sformatf("vec%0d dac_code", i),   dac_code,   tbl[i].code);
         check($sformatf("vec%0d dac_update", i), dac_update, tbl[i].upd);
         check($sformatf("vec%0d underrun", i),   underrun,   tbl[i].und);
         check($sformatf("vec%0d level", i),      level,      tbl[i].lvl);
         check($sformatf("vec%0d s_ready", i),    s_ready,    tbl[i].rdy);
      end
      underrun_clr = 1'b0;

      // Full FIFO: 9 frames offered with enable low, then pop every cycle.
      reset = 1'b1; s_valid = 1'b0; enable = 1'b0; cyc();
      reset = 1'b0;
      for (int i = 0; i < 9; i++) frames[i] = FW'($urandom);
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; s_data = frames[i]; cyc();
      end
      check("full level", level, 8);
      check("full s_ready", s_ready, 0);
      s_data = frames[8];
      cyc(); cyc();
      check("full held level", level, 8);
      enable = 1'b1; rate_div = '0;
      for (int k = 0; k < 9; k++) begin
         acc = s_valid && s_ready;
         cyc();
         if (acc) s_valid = 1'b0;
         check($sformatf("full pop%0d update", k), dac_update, 1);
         check($sformatf("full pop%0d code", k), dac_code, frames[k]);
      end
      check("full drained level", level, 0);
      s_valid = 1'b0; enable = 1'b0;

      // Reset mid-stream with frames queued and ticker running.
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = FW'($urandom); cyc();
      end
      s_valid = 1'b0; enable = 1'b1; rate_div = DIV_W'(2);
      for (int i = 0; i < 4; i++) cyc();
      reset = 1'b1; cyc();
      check("midreset level", level, 0);
      check("midreset dac_code", dac_code, 0);
      check("midreset underrun", underrun, 0);
      reset = 1'b0; s_valid = 1'b1; s_data = 20'h0ABCD; cyc();
      s_valid = 1'b0;
      cnt = 1;
      while (!dac_update && cnt < 10) begin
         cyc();
         cnt++;
      end
      check("midreset first tick cycle", cnt, 3);
      check("midreset first code", dac_code, 20'h0ABCD);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 9) == 0) begin
            enable   = 1'b0;
            rate_div = DIV_W'($urandom_range(0, 4));
         end else begin
            enable = 1'b1;
         end
         s_valid      = ($urandom_range(0, 1) == 1);
         s_data       = FW'($urandom);
         underrun_clr = ($urandom_range(0, 7) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
